// File: rtl/mdio_master_if.sv
// Request/response bundle between the control path and the MDIO master.
// The master modport is the requester, the slave modport is the MDIO block.
interface mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_phy, req_reg, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_phy, req_reg, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one 64-bit read/write frame per request,
// MDC half-period of CLK_DIV clk cycles, all pad outputs registered.
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic         clk,
    input  logic         rst,
    mdio_master_if.slave bus,
    output logic         mdc,
    output logic         mdio_o,
    output logic         mdio_oe,
    input  logic         mdio_i
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0] HDR_BIT = 6'd32;
    localparam logic [5:0] TA_BIT = 6'd46;
    localparam logic [5:0] TA2_BIT = 6'd47;
    localparam logic [5:0] DATA_BIT = 6'd48;
    localparam logic [5:0] LAST_BIT = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [63:0]   frame_q, frame_d;
    logic          write_q, write_d;
    logic          mdc_q, mdc_d;
    logic          mdo_q, mdo_d;
    logic          oe_q, oe_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ta_err_q, ta_err_d;
    logic          err_q, err_d;
    logic [63:0]   load;
    logic [5:0]    nbit;
    logic          div_end;

    function automatic state_t field_of(input logic [5:0] b);
        field_of = S_DATA;
        unique case (1'b1)
            b < HDR_BIT:                 field_of = S_PRE;
            b >= HDR_BIT && b < TA_BIT:  field_of = S_HDR;
            b >= TA_BIT && b < DATA_BIT: field_of = S_TA;
            b >= DATA_BIT:               field_of = S_DATA;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        div_d    = div_q;
        frame_d  = frame_q;
        write_d  = write_q;
        mdc_d    = mdc_q;
        mdo_d    = mdo_q;
        oe_d     = oe_q;
        valid_d  = 1'b0;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        ta_err_d = ta_err_q;
        err_d    = err_q;
        div_end  = (div_q == DIV_LAST);
        nbit     = bit_q + 6'd1;
        // Read frames leave TA/DATA as 1s; the pad is released there anyway.
        load = {32'hFFFF_FFFF, 2'b01,
                bus.req_write ? 2'b01 : 2'b10,
                bus.req_phy, bus.req_reg,
                bus.req_write ? 2'b10 : 2'b11,
                bus.req_write ? bus.req_wdata : 16'hFFFF};
        if (state_q == S_IDLE) begin
            if (bus.req_valid && ready_q) begin
                state_d  = S_PRE;
                write_d  = bus.req_write;
                bit_d    = '0;
                div_d    = '0;
                mdc_d    = 1'b0;
                mdo_d    = load[63];
                frame_d  = {load[62:0], 1'b1};
                oe_d     = 1'b1;
                shift_d  = '0;
                ta_err_d = 1'b0;
            end
        end else begin
            div_d = div_end ? '0 : div_q + 1'b1;
            if (div_end && !mdc_q) begin
                mdc_d = 1'b1;
                if (!write_q && bit_q == TA2_BIT)
                    ta_err_d = mdio_i;
                if (!write_q && state_q == S_DATA)
                    shift_d = {shift_q[14:0], mdio_i};
            end else if (div_end) begin
                mdc_d = 1'b0;
                if (bit_q == LAST_BIT) begin
                    state_d = S_IDLE;
                    mdo_d   = 1'b1;
                    oe_d    = 1'b0;
                    valid_d = 1'b1;
                    rdata_d = write_q ? 16'h0 : shift_q;
                    err_d   = write_q ? 1'b0 : ta_err_q;
                end else begin
                    bit_d   = nbit;
                    state_d = field_of(nbit);
                    mdo_d   = frame_q[63];
                    frame_d = {frame_q[62:0], 1'b1};
                    oe_d    = write_q || (nbit < TA_BIT);
                end
            end
        end
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            div_q    <= '0;
            frame_q  <= '0;
            write_q  <= 1'b0;
            mdc_q    <= 1'b0;
            mdo_q    <= 1'b1;
            oe_q     <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            shift_q  <= '0;
            rdata_q  <= '0;
            ta_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
            write_q  <= write_d;
            mdc_q    <= mdc_d;
            mdo_q    <= mdo_d;
            oe_q     <= oe_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            ta_err_q <= ta_err_d;
            err_q    <= err_d;
        end
    end

    assign mdc           = mdc_q;
    assign mdio_o        = mdo_q;
    assign mdio_oe       = oe_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: CLK_DIV=10 and CLK_DIV=2 instances, each with
// a small PHY model that answers read frames on the MDIO line.
module tb_mdio_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst10, rst2;
    mdio_master_if bus10();
    mdio_master_if bus2();
    logic mdc10, o10, oe10, mi10;
    logic mdc2, o2, oe2, mi2;

    logic        rv [2];
    logic        rw [2];
    logic [4:0]  rph [2];
    logic [4:0]  rrg [2];
    logic [15:0] rwd [2];
    logic        rdy_v [2];
    logic        rsp_v [2];
    logic        err_v [2];
    logic [15:0] rd_v [2];
    logic        mdc_v [2];
    logic        oe_v [2];
    logic        o_v [2];

    assign bus10.req_valid = rv[0];
    assign bus10.req_write = rw[0];
    assign bus10.req_phy   = rph[0];
    assign bus10.req_reg   = rrg[0];
    assign bus10.req_wdata = rwd[0];
    assign bus2.req_valid  = rv[1];
    assign bus2.req_write  = rw[1];
    assign bus2.req_phy    = rph[1];
    assign bus2.req_reg    = rrg[1];
    assign bus2.req_wdata  = rwd[1];
    assign rdy_v[0] = bus10.req_ready;
    assign rsp_v[0] = bus10.rsp_valid;
    assign err_v[0] = bus10.rsp_error;
    assign rd_v[0]  = bus10.rsp_rdata;
    assign rdy_v[1] = bus2.req_ready;
    assign rsp_v[1] = bus2.rsp_valid;
    assign err_v[1] = bus2.rsp_error;
    assign rd_v[1]  = bus2.rsp_rdata;
    assign mdc_v[0] = mdc10;
    assign oe_v[0]  = oe10;
    assign o_v[0]   = o10;
    assign mdc_v[1] = mdc2;
    assign oe_v[1]  = oe2;
    assign o_v[1]   = o2;

    mdio_master #(.CLK_DIV(10)) u10 (
        .clk(clk), .rst(rst10), .bus(bus10.slave),
        .mdc(mdc10), .mdio_o(o10), .mdio_oe(oe10), .mdio_i(mi10)
    );
    mdio_master #(.CLK_DIV(2)) u2 (
        .clk(clk), .rst(rst2), .bus(bus2.slave),
        .mdc(mdc2), .mdio_o(o2), .mdio_oe(oe2), .mdio_i(mi2)
    );

    logic        phy_on [2];
    logic [15:0] phy_data [2];
    logic        drv_en [2];
    logic        drv_val [2];
    int   rise_cnt [2] = '{0, 0};
    logic mdc_p [2] = '{1'b0, 1'b0};
    int   run_len [2] = '{0, 0};
    int   hi_min [2] = '{999, 999};
    int   hi_max [2] = '{0, 0};
    int   lo_min [2] = '{999, 999};
    int   lo_max [2] = '{0, 0};
    int   rsp_cnt [2] = '{0, 0};
    logic bits_o [2][64];
    logic bits_oe [2][64];
    logic start_oe [2][64];
    int   cyc = 0;

    // Pull-up when nobody drives the net.
    assign mi10 = oe10 ? o10 : (drv_en[0] ? drv_val[0] : 1'b1);
    assign mi2  = oe2 ? o2 : (drv_en[1] ? drv_val[1] : 1'b1);

    // PHY drives TA bit 47 low and data bits 48..63 after each MDC rise.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            drv_en[i]  = 1'b0;
            drv_val[i] = 1'b1;
            if (phy_on[i] && !rdy_v[i]) begin
                if (rise_cnt[i] == 47) begin
                    drv_en[i]  = 1'b1;
                    drv_val[i] = 1'b0;
                end else if (rise_cnt[i] >= 48 && rise_cnt[i] <= 63) begin
                    drv_en[i]  = 1'b1;
                    drv_val[i] = phy_data[i][4'(63 - rise_cnt[i])];
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mdc_p[i] <= mdc_v[i];
            if (rsp_v[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
            if (rdy_v[i]) begin
                rise_cnt[i] <= 0;
            end else if (mdc_v[i] && !mdc_p[i] && rise_cnt[i] < 64) begin
                bits_o[i][6'(rise_cnt[i])]  <= o_v[i];
                bits_oe[i][6'(rise_cnt[i])] <= oe_v[i];
                rise_cnt[i] <= rise_cnt[i] + 1;
            end else if (!mdc_v[i] && mdc_p[i] && rise_cnt[i] < 64) begin
                start_oe[i][6'(rise_cnt[i])] <= oe_v[i];
            end
            if (mdc_v[i] != mdc_p[i]) begin
                run_len[i] <= 1;
                if (mdc_p[i]) begin
                    if (run_len[i] < hi_min[i]) hi_min[i] <= run_len[i];
                    if (run_len[i] > hi_max[i]) hi_max[i] <= run_len[i];
                end else if (rise_cnt[i] > 0 && !rdy_v[i]) begin
                    if (run_len[i] < lo_min[i]) lo_min[i] <= run_len[i];
                    if (run_len[i] > lo_max[i]) lo_max[i] <= run_len[i];
                end
            end else begin
                run_len[i] <= run_len[i] + 1;
            end
        end
    end

    int pass_n = 0;
    int tot_n = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tot_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    task automatic start_req(input int i, input logic w,
                             input logic [4:0] ph, input logic [4:0] rg,
                             input logic [15:0] wd, output int a);
        int k;
        k = 0;
        while (!rdy_v[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        rw[i] = w;
        rph[i] = ph;
        rrg[i] = rg;
        rwd[i] = wd;
        rv[i] = 1'b1;
        a = cyc;
        @(negedge clk);
        rv[i] = 1'b0;
        chk("ready_low_after_accept", int'(rdy_v[i]), 0);
    endtask

    task automatic wait_rsp(input int i, input int a, output int lat);
        lat = -1;
        for (int n = 0; n < 3000 && lat < 0; n++) begin
            if (rsp_v[i]) lat = cyc - a;
            else @(negedge clk);
        end
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  ph;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        on;
        logic [15:0] pd;
        logic [15:0] hdr;
        logic [15:0] erd;
        logic        eer;
    } vec_t;

    vec_t vt [5];
    int   a, lat, e, nb, base, hi, k;
    logic [63:0] exp_f;

    initial begin
        vt[0] = '{1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0,
                  16'h5082, 16'h0, 1'b0};
        vt[1] = '{1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 16'h796D,
                  16'h6088, 16'h796D, 1'b0};
        vt[2] = '{1'b0, 5'd3, 5'd1, 16'h0, 1'b0, 16'h0,
                  16'h6184, 16'hFFFF, 1'b1};
        vt[3] = '{1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0,
                  16'h5FFE, 16'h0, 1'b0};
        vt[4] = '{1'b0, 5'h12, 5'h0C, 16'h0, 1'b1, 16'h8001,
                  16'h6930, 16'h8001, 1'b0};
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0;
            rw[i] = 1'b0;
            rph[i] = '0;
            rrg[i] = '0;
            rwd[i] = '0;
            phy_on[i] = 1'b0;
            phy_data[i] = '0;
        end
        rst10 = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state",
            int'({mdc10, o10, oe10, rdy_v[0], rsp_v[0], err_v[0], rd_v[0]}),
            int'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
        rst10 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("ready_after_reset10", int'(rdy_v[0]), 1);
        chk("ready_after_reset2", int'(rdy_v[1]), 1);

        for (int v = 0; v < 5; v++) begin
            phy_on[0] = vt[v].on;
            phy_data[0] = vt[v].pd;
            start_req(0, vt[v].w, vt[v].ph, vt[v].rg, vt[v].wd, a);
            wait_rsp(0, a, lat);
            chk("latency", lat, 1281);
            chk("rdata", int'(rd_v[0]), int'(vt[v].erd));
            chk("error", int'(err_v[0]), int'(vt[v].eer));
            chk("idle_on_rsp", int'({mdc10, oe10, rdy_v[0]}), 1);
            exp_f = {32'hFFFF_FFFF, vt[v].hdr,
                     vt[v].w ? vt[v].wd : 16'h0};
            nb = vt[v].w ? 64 : 46;
            e = 0;
            for (int n = 0; n < nb; n++)
                if (bits_o[0][n] !== exp_f[63-n]) e++;
            chk("frame_bits", e, 0);
            e = 0;
            for (int n = 0; n < 64; n++)
                if (bits_oe[0][n] !== (vt[v].w || n < 46)) e++;
            if (start_oe[0][46] !== vt[v].w) e++;
            if (start_oe[0][45] !== 1'b1) e++;
            chk("oe_pattern", e, 0);
        end

        // Back-to-back: valid held high through a write then a read.
        @(negedge clk);
        phy_on[0] = 1'b1;
        phy_data[0] = 16'h1234;
        base = rsp_cnt[0];
        rw[0] = 1'b1;
        rph[0] = 5'd1;
        rrg[0] = 5'd4;
        rwd[0] = 16'h0A0A;
        rv[0] = 1'b1;
        @(negedge clk);
        rw[0] = 1'b0;
        rrg[0] = 5'd1;
        hi = 0;
        k = 0;
        while (!rsp_v[0] && k < 3000) begin
            if (rdy_v[0]) hi++;
            @(negedge clk);
            k++;
        end
        chk("b2b_rsp1_seen", int'(rsp_v[0]), 1);
        chk("b2b_ready_low", hi, 0);
        @(negedge clk);
        chk("b2b_next_start", int'({mdc10, oe10, o10, rdy_v[0]}), 6);
        rv[0] = 1'b0;
        k = 0;
        while (!rsp_v[0] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_rsp2_seen", int'(rsp_v[0]), 1);
        chk("b2b_rdata", int'(rd_v[0]), 16'h1234);
        chk("b2b_error", int'(err_v[0]), 0);
        chk("b2b_op_read", int'({bits_o[0][34], bits_o[0][35]}), 2);
        repeat (100) @(negedge clk);
        chk("b2b_pulses", rsp_cnt[0] - base, 2);

        // Reset in the middle of write data bit 50.
        phy_on[0] = 1'b0;
        start_req(0, 1'b1, 5'd1, 5'd0, 16'hBEEF, a);
        k = 0;
        while (!(rise_cnt[0] == 50 && !mdc10) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_bit50", rise_cnt[0], 50);
        base = rsp_cnt[0];
        rst10 = 1'b1;
        @(negedge clk);
        rst10 = 1'b0;
        chk("rst_mid_outputs",
            int'({mdc10, oe10, rsp_v[0], rdy_v[0], o10}), 1);
        @(negedge clk);
        chk("rst_ready_back", int'(rdy_v[0]), 1);
        phy_on[0] = 1'b1;
        phy_data[0] = 16'h5A5A;
        start_req(0, 1'b0, 5'd4, 5'd7, 16'h0, a);
        wait_rsp(0, a, lat);
        chk("rst_read_latency", lat, 1281);
        chk("rst_read_rdata", int'(rd_v[0]), 16'h5A5A);
        chk("rst_read_error", int'(err_v[0]), 0);
        @(negedge clk);
        chk("rst_no_extra_rsp", rsp_cnt[0] - base, 1);

        // Minimum divider.
        phy_on[1] = 1'b1;
        phy_data[1] = 16'hC3A5;
        start_req(1, 1'b0, 5'd2, 5'd3, 16'h0, a);
        wait_rsp(1, a, lat);
        chk("div2_latency", lat, 257);
        chk("div2_rdata", int'(rd_v[1]), 16'hC3A5);
        chk("div2_error", int'(err_v[1]), 0);
        @(negedge clk);
        chk("div2_hi_min", hi_min[1], 2);
        chk("div2_hi_max", hi_max[1], 2);
        chk("div2_lo_min", lo_min[1], 2);
        chk("div2_lo_max", lo_max[1], 2);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
